u_rec_fifo: RTL and testbench



---
 rtl/u_rec_fifo_pkg.sv | 11 +
 rtl/u_rec_edge_qual.sv | 34 +++
 rtl/u_rec_fifo.sv | 85 ++++++++
 tb/tb_u_rec_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/u_rec_fifo_pkg.sv
// Shared receive-path constants: byte width, default FIFO/qualifier sizing, logic levels.
package u_rec_fifo_pkg;
    localparam int   BYTE_W          = 8;
    localparam int   DEF_DEPTH       = 8;
    localparam int   DEF_MIN_LOW_CYC = 64;
    localparam int   DEF_LVL_THRESH  = 4;
    localparam logic HI              = 1'b1;
    localparam logic LO              = 1'b0;

    typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/u_rec_edge_qual.sv
// Turns the receiver's ready rising edge into a one-cycle write strobe, but only
// after ready has been low long enough to be a real frame (filters false starts).
module u_rec_edge_qual
    import u_rec_fifo_pkg::*;
#(
    parameter int MIN_LOW_CYC = DEF_MIN_LOW_CYC
) (
    input  logic sys_clk,
    input  logic sys_rstH,
    input  logic rec_readyH,
    output logic wrH
);
    localparam int            CW      = $clog2(MIN_LOW_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MIN_LOW_CYC);

    logic          rdy_dH;
    logic [CW-1:0] lowCntH;

    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            rdy_dH  <= HI;
            lowCntH <= '0;
        end else begin
            rdy_dH <= rec_readyH;
            // Saturate so arbitrarily long lows still qualify on the stop edge.
            if (rec_readyH)
                lowCntH <= '0;
            else if (lowCntH != CNT_MAX)
                lowCntH <= lowCntH + 1'b1;
        end
    end

    assign wrH = rec_readyH & ~rdy_dH & (lowCntH == CNT_MAX);
endmodule

// File: rtl/u_rec_fifo.sv
// Receive FIFO behind the UART receiver: qualified byte capture, FWFT read port, sticky overrun.
// Define RX_LEVEL_IRQ_EN to build the registered level/overrun interrupt on irqH.
module u_rec_fifo
    import u_rec_fifo_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int MIN_LOW_CYC = DEF_MIN_LOW_CYC,
    parameter int LVL_THRESH  = DEF_LVL_THRESH
) (
    input  logic                     sys_clk,
    input  logic                     sys_rstH,
    input  logic [BYTE_W-1:0]        rec_dataH,
    input  logic                     rec_readyH,
    output logic [BYTE_W-1:0]        rd_dataH,
    output logic                     rd_validH,
    input  logic                     rd_readyH,
    output logic [$clog2(DEPTH):0]   fifo_levelH,
    output logic                     overrunH,
    input  logic                     ovr_clrH,
    output logic                     irqH
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    byte_t          mem [DEPTH];
    logic [LW-1:0]  wrPtr, rdPtr, level;
    logic           wrH, pop, full, accept, drop;

    u_rec_edge_qual #(
        .MIN_LOW_CYC (MIN_LOW_CYC)
    ) uEdgeQual (
        .sys_clk    (sys_clk),
        .sys_rstH   (sys_rstH),
        .rec_readyH (rec_readyH),
        .wrH        (wrH)
    );

    // Extra pointer bit lets full and empty be told apart by plain subtraction.
    assign level  = wrPtr - rdPtr;
    assign full   = (level == LW'(DEPTH));
    assign pop    = rd_validH & rd_readyH;
    assign accept = wrH & (~full | pop);
    assign drop   = wrH & full & ~pop;

    assign fifo_levelH = level;
    assign rd_validH   = (level != '0);
    assign rd_dataH    = mem[rdPtr[AW-1:0]];

    always_ff @(posedge sys_clk) begin
        if (sys_rstH) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            overrunH <= LO;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wrPtr[AW-1:0]] <= rec_dataH;
                wrPtr              <= wrPtr + 1'b1;
            end
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            // A fresh drop outranks a simultaneous clear so no overrun is lost.
            if (drop)
                overrunH <= HI;
            else if (ovr_clrH)
                overrunH <= LO;
        end
    end

`ifdef RX_LEVEL_IRQ_EN
    logic irqQ;

    always_ff @(posedge sys_clk) begin
        if (sys_rstH)
            irqQ <= LO;
        else
            irqQ <= (level >= LW'(LVL_THRESH)) | overrunH;
    end

    assign irqH = irqQ;
`else
    assign irqH = LO;
`endif
endmodule

// File: tb/tb_u_rec_fifo.sv
// Self-checking bench for u_rec_fifo: directed table, hand sequences, random frames vs queue model.
module tb_u_rec_fifo;
    localparam int DEPTH = 8;
    localparam int MINL  = 64;
    localparam int THR   = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rstH, rec_readyH, rd_readyH, ovr_clrH;
    logic [7:0] rec_dataH, rd_dataH;
    logic       rd_validH, overrunH, irqH;
    logic [3:0] fifo_levelH;

    always #5 sys_clk = ~sys_clk;

    u_rec_fifo #(.DEPTH(DEPTH), .MIN_LOW_CYC(MINL), .LVL_THRESH(THR)) dut (
        .sys_clk     (sys_clk),
        .sys_rstH    (sys_rstH),
        .rec_dataH   (rec_dataH),
        .rec_readyH  (rec_readyH),
        .rd_dataH    (rd_dataH),
        .rd_validH   (rd_validH),
        .rd_readyH   (rd_readyH),
        .fifo_levelH (fifo_levelH),
        .overrunH    (overrunH),
        .ovr_clrH    (ovr_clrH),
        .irqH        (irqH)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue, sticky flag, length of the current low run.
    logic [7:0] q[$];
    bit         mOvr, mPrev, mIrq;
    int         mLow;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mOvr  = 1'b0;
        mPrev = 1'b1;
        mIrq  = 1'b0;
        mLow  = 0;
    endtask

    task automatic tick();
        bit pop, wr, setO, accept, nIrq;
        logic [7:0] d;
        pop    = (q.size() != 0) && rd_readyH;
        wr     = rec_readyH && !mPrev && (mLow >= MINL);
        setO   = wr && (q.size() >= DEPTH) && !pop;
        accept = wr && !setO;
        d      = rec_dataH;
`ifdef RX_LEVEL_IRQ_EN
        nIrq = (q.size() >= THR) || mOvr;
`else
        nIrq = 1'b0;
`endif
        @(posedge sys_clk);
        #1;
        if (sys_rstH) begin
            modelReset();
        end else begin
            if (pop) void'(q.pop_front());
            if (accept) q.push_back(d);
            if (setO) mOvr = 1'b1;
            else if (ovr_clrH) mOvr = 1'b0;
            mLow  = rec_readyH ? 0 : mLow + 1;
            mPrev = rec_readyH;
            mIrq  = nIrq;
        end
        chk("m_level", int'(fifo_levelH), q.size());
        chk("m_valid", int'(rd_validH), int'(q.size() != 0));
        chk("m_overrun", int'(overrunH), int'(mOvr));
        chk("m_irq", int'(irqH), int'(mIrq));
        if (q.size() != 0) chk("m_data", int'(rd_dataH), int'(q[0]));
    endtask

    task automatic doReset();
        sys_rstH = 1'b1;
        tick();
        sys_rstH = 1'b0;
    endtask

    // One receiver frame: ready low for lowCyc cycles, then the stop edge.
    task automatic frame(input int lowCyc, input logic [7:0] d, input bit popAtEdge);
        rec_dataH  = d;
        rec_readyH = 1'b0;
        rd_readyH  = 1'b0;
        repeat (lowCyc) tick();
        rec_readyH = 1'b1;
        rd_readyH  = popAtEdge;
        tick();
        rd_readyH  = 1'b0;
    endtask

    typedef struct {
        int         lowCyc;
        logic [7:0] d;
        bit         popE;
        bit         drain;
        int         expLvl;
        bit         expOvr;
        logic [7:0] expHead;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0] = '{150, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 8'hA5};
        tbl[1] = '{5,   8'h33, 1'b0, 1'b0, 1, 1'b0, 8'hA5};
        tbl[2] = '{63,  8'h44, 1'b0, 1'b0, 1, 1'b0, 8'hA5};
        tbl[3] = '{64,  8'h55, 1'b0, 1'b0, 2, 1'b0, 8'hA5};
        for (int k = 1; k <= 9; k++)
            tbl[3+k] = '{64 + k, 8'(k), 1'b0, (k == 1), (k > 8) ? 8 : k, (k == 9), 8'h01};

        sys_rstH   = 1'b1;
        rec_readyH = 1'b1;
        rd_readyH  = 1'b0;
        ovr_clrH   = 1'b0;
        rec_dataH  = 8'h00;
        modelReset();
        tick();
        tick();
        sys_rstH = 1'b0;
        chk("rst_level", int'(fifo_levelH), 0);
        chk("rst_valid", int'(rd_validH), 0);
        chk("rst_data", int'(rd_dataH), 0);
        chk("rst_ovr", int'(overrunH), 0);
        chk("rst_irq", int'(irqH), 0);

        repeat (200) tick();
        chk("idle_level", int'(fifo_levelH), 0);
        chk("idle_valid", int'(rd_validH), 0);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].drain) begin
                rd_readyH = 1'b1;
                for (int n = 0; n < DEPTH + 2 && rd_validH; n++) tick();
                rd_readyH = 1'b0;
                chk("drain_timeout", int'(rd_validH), 0);
            end
            frame(tbl[i].lowCyc, tbl[i].d, tbl[i].popE);
            chk($sformatf("vec%0d_level", i), int'(fifo_levelH), tbl[i].expLvl);
            chk($sformatf("vec%0d_ovr", i), int'(overrunH), int'(tbl[i].expOvr));
            if (tbl[i].expLvl != 0)
                chk($sformatf("vec%0d_head", i), int'(rd_dataH), int'(tbl[i].expHead));
        end

        for (int k = 1; k <= 8; k++) begin
            chk("ovf_readout", int'(rd_dataH), k);
            rd_readyH = 1'b1;
            tick();
        end
        rd_readyH = 1'b0;
        chk("ovf_empty", int'(rd_validH), 0);
        chk("ovf_sticky", int'(overrunH), 1);
        ovr_clrH = 1'b1;
        tick();
        ovr_clrH = 1'b0;
        chk("ovf_clr", int'(overrunH), 0);

        doReset();
        for (int k = 1; k <= 8; k++) frame(70, 8'(k), 1'b0);
        frame(70, 8'h09, 1'b1);
        chk("fullpop_level", int'(fifo_levelH), 8);
        chk("fullpop_ovr", int'(overrunH), 0);
        for (int k = 2; k <= 9; k++) begin
            chk("fullpop_readout", int'(rd_dataH), k);
            rd_readyH = 1'b1;
            tick();
        end
        rd_readyH = 1'b0;
        chk("fullpop_empty", int'(fifo_levelH), 0);

        rec_dataH  = 8'h5A;
        rec_readyH = 1'b0;
        repeat (90) tick();
        doReset();
        repeat (20) tick();
        rec_readyH = 1'b1;
        tick();
        tick();
        chk("midrst_level", int'(fifo_levelH), 0);
        chk("midrst_data", int'(rd_dataH), 0);

        doReset();
        for (int k = 1; k <= 3; k++) frame(70, 8'(k + 16), 1'b0);
        tick();
        chk("irq_lvl3", int'(irqH), 0);
        frame(70, 8'h14, 1'b0);
        chk("irq_lvl4_now", int'(irqH), 0);
        tick();
`ifdef RX_LEVEL_IRQ_EN
        chk("irq_lvl4_next", int'(irqH), 1);
`else
        chk("irq_off", int'(irqH), 0);
`endif
        rd_readyH = 1'b1;
        tick();
        rd_readyH = 1'b0;
        tick();
        chk("irq_after_pop", int'(irqH), 0);

        doReset();
        for (int f = 0; f < 40; f++) begin
            int lowLen, gap;
            lowLen     = $urandom_range(1, 120);
            gap        = $urandom_range(1, 10);
            rec_dataH  = 8'($urandom);
            rec_readyH = 1'b0;
            for (int c = 0; c < lowLen + gap; c++) begin
                if (c == lowLen) rec_readyH = 1'b1;
                rd_readyH = ($urandom_range(0, 3) == 0);
                ovr_clrH  = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        rd_readyH = 1'b0;
        ovr_clrH  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
